// File: rtl/signed_divider_pkg.sv
// Shared definitions for the signed divider.
// Holds the FSM state encoding and the default datapath width. The
// multiplier and the 7-segment display path use the same width constant.
package signed_divider_pkg;

    // Default operand/result width used across the arithmetic units
    localparam int SD_WIDTH = 8;

    // State encoding constants
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX
    } sd_state_e;

endpackage

// File: rtl/signed_divider_if.sv
// Request/result bundle for the signed divider.
//   start, dividend, divisor              : requester -> divider
//   quotient, remainder, sign, busy, done,
//   div_by_zero, overflow                 : divider -> requester
// The master modport is used by the requester, the slave modport by the divider.
interface signed_divider_if
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = SD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             sign;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, sign, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, sign, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/sd_twos_mag.sv
// Combinational two's-complement magnitude/negate unit.
//   val_i : WIDTH-bit input value
//   neg_i : 1 = output the two's-complement negation of val_i
//   res_o : neg_i ? -val_i : val_i
// Used for taking operand magnitudes and for re-applying result signs.
module sd_twos_mag
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = SD_WIDTH
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Conditional negation; -(-2^(WIDTH-1)) wraps to itself, which reads
    // correctly as the unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        if (neg_i) begin
            res_o = ~val_i + ONE;
        end else begin
            res_o = val_i;
        end
    end
endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider (restoring division on magnitudes, one
// quotient bit per clock).
//   sys_clk : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : slave side of signed_divider_if (start/operands in,
//             quotient/remainder/sign/busy/done/div_by_zero/overflow out)
// Result latency is WIDTH+2 edges from the accepted start (2 for divide by 0).
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = SD_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    signed_divider_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    sd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;      // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] b_q, b_d;      // divisor magnitude
    logic [WIDTH-1:0] p_q, p_d;      // partial remainder
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
    logic [WIDTH-1:0] q_src_s, r_src_s, q_fix_s, r_fix_s;
    logic [WIDTH:0]   shifted_s, trial_s;
    logic             dz_s;

    sd_twos_mag #(.WIDTH(WIDTH)) u_dvd_mag (.val_i(bus.dividend), .neg_i(bus.dividend[WIDTH-1]), .res_o(dvd_mag_s));
    sd_twos_mag #(.WIDTH(WIDTH)) u_dvs_mag (.val_i(bus.divisor),  .neg_i(bus.divisor[WIDTH-1]),  .res_o(dvs_mag_s));
    sd_twos_mag #(.WIDTH(WIDTH)) u_q_fix   (.val_i(q_src_s), .neg_i(q_neg_q), .res_o(q_fix_s));
    sd_twos_mag #(.WIDTH(WIDTH)) u_r_fix   (.val_i(r_src_s), .neg_i(r_neg_q), .res_o(r_fix_s));

    // Datapath helpers: WIDTH+1-bit trial subtraction and divide-by-zero source muxing.
    // The partial remainder is always below the divisor magnitude, so the
    // shifted value fits in WIDTH+1 bits and the MSB of the difference is its sign.
    always_comb begin
        shifted_s = {p_q, a_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, b_q};
        dz_s      = (b_q == '0);
        if (dz_s) begin
            q_src_s = '0;
            r_src_s = a_q;           // remainder = dividend when dividing by zero
        end else begin
            q_src_s = a_q;
            r_src_s = p_q;
        end
    end

    // Next-state and output-register logic of the divider FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ov_d    = ov_q;
        sign_d  = sign_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = dvd_mag_s;
                    b_d     = dvs_mag_s;
                    q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    r_neg_d = bus.dividend[WIDTH-1];
                    p_d     = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_d   = {a_q[WIDTH-2:0], ~trial_s[WIDTH]};
                cnt_d = cnt_q - CNT_ONE;
                if (trial_s[WIDTH]) begin
                    p_d = shifted_s[WIDTH-1:0];      // restore
                end else begin
                    p_d = trial_s[WIDTH-1:0];
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                quot_d  = q_fix_s;
                rem_d   = r_fix_s;
                // A zero quotient is never reported as negative.
                sign_d  = q_neg_q & (|q_src_s);
                dz_d    = dz_s;
                // Magnitude 2^(WIDTH-1) with positive sign only arises from MIN / -1.
                ov_d    = ~dz_s & a_q[WIDTH-1] & ~q_neg_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            sign_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            sign_q  <= sign_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.sign        = sign_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for signed_divider (8-bit default).
module tb_signed_divider;
    import signed_divider_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   op_num = 0;

    always #5 clk = ~clk;

    signed_divider_if #(.WIDTH(W)) dif ();

    signed_divider #(.WIDTH(W), .CNT_W(4)) dut (
        .sys_clk (clk),
        .rst     (rst_n),
        .bus     (dif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/op%0d: got %0h expected %0h", tag, op_num, obs, exp);
        end
    endtask

    // Wait for done after the accept edge; lat counts edges since the accept edge.
    task automatic wait_done(inout int lat, output int got);
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (dif.done) got = 1;
        end
    endtask

    task automatic check_result(input int lat, input int got, input int elat,
                                input logic [7:0] eq, input logic [7:0] er,
                                input logic es, input logic edz, input logic eov);
        chk("done_seen", got, 1);
        chk("latency", lat, elat);
        chk("quotient", dif.quotient, eq);
        chk("remainder", dif.remainder, er);
        chk("sign", dif.sign, es);
        chk("div_by_zero", dif.div_by_zero, edz);
        chk("overflow", dif.overflow, eov);
        chk("busy_at_done", dif.busy, 1'b0);
        @(posedge clk);
        #1;
        chk("done_pulse", dif.done, 1'b0);
        chk("hold_q", dif.quotient, eq);
    endtask

    task automatic do_op(input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic es, input logic edz, input logic eov, input int elat);
        int lat;
        int got;
        op_num++;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = dvd;
        dif.divisor  = dvs;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        chk("busy_after_start", dif.busy, 1'b1);
        lat = 0;
        wait_done(lat, got);
        check_result(lat, got, elat, eq, er, es, edz, eov);
    endtask

    initial begin
        int lat;
        int got;
        int seen;
        dif.start    = 1'b0;
        dif.dividend = 8'h00;
        dif.divisor  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_quotient", dif.quotient, 8'h00);
        chk("rst_remainder", dif.remainder, 8'h00);
        chk("rst_busy", dif.busy, 1'b0);
        chk("rst_done", dif.done, 1'b0);
        chk("rst_flags", {dif.sign, dif.div_by_zero, dif.overflow}, 3'b000);
        rst_n = 1'b1;

        //     dividend divisor  quot   rem    s     dz    ov    lat
        do_op(8'd91,   8'd7,    8'd13, 8'd0,  1'b0, 1'b0, 1'b0, 9);
        do_op(8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b1, 1'b0, 1'b0, 9);   // -100/7
        do_op(8'd100,  8'hF9,   8'hF2, 8'h02, 1'b1, 1'b0, 1'b0, 9);   // 100/-7
        do_op(8'h9C,   8'hF9,   8'h0E, 8'hFE, 1'b0, 1'b0, 1'b0, 9);   // -100/-7
        do_op(8'd5,    8'd0,    8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 1);   // divide by zero
        do_op(8'hFD,   8'd7,    8'h00, 8'hFD, 1'b0, 1'b0, 1'b0, 9);   // -3/7 clears dz
        do_op(8'd7,    8'd91,   8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 9);
        do_op(8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 9);   // -128/-1
        do_op(8'h80,   8'd1,    8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 9);   // -128/1

        // Start while busy is ignored
        op_num++;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'd91; dif.divisor = 8'd7;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        dif.start = 1'b1; dif.dividend = 8'd50; dif.divisor = 8'd5;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        chk("busy_ignore", dif.busy, 1'b1);
        lat = 3;
        wait_done(lat, got);
        check_result(lat, got, 9, 8'd13, 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation aborts without done
        op_num++;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 8'h9C; dif.divisor = 8'd7;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", dif.busy, 1'b0);
        chk("abort_quotient", dif.quotient, 8'h00);
        chk("abort_remainder", dif.remainder, 8'h00);
        chk("abort_done", dif.done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (dif.done) seen = 1;
        end
        chk("abort_nodone", seen, 0);

        do_op(8'd91, 8'd7, 8'd13, 8'd0, 1'b0, 1'b0, 1'b0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
